at_cmd_uart_tx: RTL and testbench
=================================

# at_cmd_uart_tx

Serializes the 144-bit AT-command buffer produced by the Bluetooth command encoder onto the UART line driving the BLE module. It accepts one buffer per `start` pulse and transmits bytes in order from byte 0 (bits [7:0]) upward as 8N1 frames. Transmission ends after the first carriage-return byte (0x0D) is sent, or after all 18 bytes if no carriage return is present. It sits directly downstream of the encoder: the encoder's `output_data`/`done` feed this block's `cmd_data`/`start`.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Minimum legal value is 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_data`  in  144: command buffer; byte k = bits [8k+7:8k], k = 0..17. Sampled only when a start is accepted.
- `start`  in  1: request to transmit `cmd_data`. Level-sampled.
- `tx`  out  1: UART serial output; idle high.
- `busy`  out  1: high from start acceptance until the final stop bit completes.
- `done`  out  1: one-cycle pulse when the transmission completes.
- `byte_count`  out  5: number of bytes fully transmitted in the current or last transfer (0..18).

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, `byte_count`=0, FSM=IDLE, bit and baud counters = 0.
- FSM states: IDLE, START_BIT, DATA, STOP, FINISH.
- IDLE:
  - If `start`=1 at a clock edge: latch `cmd_data` into the shift buffer, clear `byte_count`, set `busy`=1, go to START_BIT.
  - Otherwise hold `tx`=1.
- START_BIT: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: send the current byte LSB first, each bit held for CLKS_PER_BIT cycles. A 3-bit counter selects the bit. After bit 7, go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end of the stop bit, increment `byte_count`. Then:
  - If the byte just sent equals 0x0D, or `byte_count` reaches 18: go to FINISH.
  - Otherwise shift the buffer right by 8 and go to START_BIT. There is no inter-byte idle gap.
- FINISH: lasts one cycle. `done`=1, `busy`=0, `tx`=1. Next state is IDLE.
- Boundary conditions:
  - `start` while `busy`=1 or in FINISH is ignored and is not queued.
  - `start` held high continuously restarts a transfer in the IDLE cycle after FINISH. The encoder pulses its `done` only once, so this does not occur in normal use.
  - A 0x0D inside the data payload terminates the transfer early. This is the accepted protocol behaviour.
  - A buffer with no 0x0D (for example the encoder's all-ones error pattern) sends all 18 bytes.
  - Reset mid-frame: `tx` returns to 1 immediately (asynchronously), the FSM goes to IDLE, and no `done` pulse is generated.
- Width rules:
  - Baud counter is $clog2(CLKS_PER_BIT) bits wide and counts 0..CLKS_PER_BIT-1.
  - `byte_count` saturates at 18.

## Timing
- Edge E0 is the edge at which `start` is accepted.
- After E0, `tx`=0 and `busy`=1.
- Each bit occupies exactly CLKS_PER_BIT cycles. One frame is 10·CLKS_PER_BIT cycles.
- For N bytes sent, `done` is high in the cycle following edge E0 + 10·N·CLKS_PER_BIT. In that same cycle `busy`=0.
- A new `start` can be accepted at the next edge.
- Latency from start acceptance to the first falling edge of `tx` is 0 cycles (registered at E0).

## Structure
- Shared package `bt_pkg`:
  - constants `ASCII_CR` = 8'h0D, `CMD_BYTES` = 18, `CMD_WIDTH` = 144;
  - the FSM state enum.
  - The encoder and this block both import it.
- One natural sub-module: `uart_tx_byte`.
  - Handles the start, data and stop bit timing for a single byte with a `valid`/`ready` handshake.
  - The top level holds the buffer, `byte_count` and terminator logic.

## Test plan
All scenarios use CLKS_PER_BIT=4.

- **TX command:** buffer "AT+BLEUARTTX=" followed by payload bytes 31 32 33 34 and 0D.
  - Required response: 18 frames decoded as 41 54 2B 42 4C 45 55 41 52 54 54 58 3D 31 32 33 34 0D.
  - `done` 720 cycles after E0; `byte_count`=18.
- **RX command:** "AT+BLEUARTRX" followed by 0D, upper bytes 0.
  - Required response: exactly 13 frames, the last being 0D.
  - `done` at 520 cycles; `byte_count`=13; `tx` idle high afterwards.
- **No terminator:** all-ones buffer.
  - Required response: 18 frames of FF; `done` at 720 cycles.
- **Start while busy:** second `start` pulse during byte 3.
  - Required response: ignored; exactly one `done` pulse; frame count unchanged.
- **Reset mid-transfer:** assert `reset` during data bit 4 of byte 2.
  - Required response: `tx`=1 asynchronously; `busy`=0; no `done` pulse.
  - A new `start` afterwards transmits correctly from byte 0.
- **Back-to-back:** `start` asserted in the IDLE cycle immediately after the `done` pulse.
  - Required response: accepted; the first falling edge of `tx` follows at that edge.

Source files
------------

// File: rtl/bt_pkg.sv
// Shared definitions for the Bluetooth AT-command path (encoder and UART
// transmitter).
//   ASCII_CR   : command terminator byte
//   CMD_BYTES  : bytes in one command buffer
//   CMD_WIDTH  : command buffer width in bits
//   tx_state_t : UART transmitter FSM states
package bt_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam int         CMD_BYTES = 18;
  localparam int         CMD_WIDTH = CMD_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    FINISH    = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer with a valid/ready byte interface.
//   clk, reset : clock, asynchronous active-high reset
//   valid      : a byte is offered on data
//   data       : byte to send, LSB first
//   ready      : byte slot free this cycle (idle, or last cycle of a stop bit)
//   idle       : FSM is in IDLE
//   tx         : serial line, idle high
//   busy       : a frame sequence is in progress
//   done       : one-cycle pulse after the final stop bit
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | line high, waiting for valid
// START_BIT | line low for one bit time
// DATA      | eight data bits, LSB first
// STOP      | line high for one bit time; chain next byte or finish
// FINISH    | one cycle, done pulse
module uart_tx_byte
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       idle,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        shreg, sh_n;
  logic              tx_n;
  logic              baud_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      tx       <= tx_n;
    end
  end

  always_comb begin
    baud_end = (baud_cnt == BAUD_LAST);
    state_n  = state;
    baud_n   = baud_end ? '0 : baud_cnt + 1'b1;
    bit_n    = bit_cnt;
    sh_n     = shreg;
    tx_n     = tx;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        baud_n = '0;
        tx_n   = 1'b1;
        if (valid) begin
          state_n = START_BIT;
          sh_n    = data;
          tx_n    = 1'b0;
        end
      end
      START_BIT: begin
        if (baud_end) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shreg[0];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n = bit_cnt + 3'd1;
            sh_n  = shreg >> 1;
            tx_n  = shreg[1];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          // Next byte's start bit begins on the edge that ends this stop bit.
          ready = 1'b1;
          if (valid) begin
            state_n = START_BIT;
            sh_n    = data;
            tx_n    = 1'b0;
          end else begin
            state_n = FINISH;
            tx_n    = 1'b1;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
      end
    endcase
  end

  assign idle = (state == IDLE);
  assign busy = (state == START_BIT) || (state == DATA) || (state == STOP);
  assign done = (state == FINISH);

endmodule

// File: rtl/at_cmd_uart_tx.sv
// Sends a 144-bit AT-command buffer as consecutive 8N1 frames, byte 0 first,
// stopping after the first carriage return or after all 18 bytes.
//   clk, reset : clock, asynchronous active-high reset
//   cmd_data   : command buffer, byte k at [8k+7:8k], sampled on accept
//   start      : transmit request, level-sampled while idle
//   tx         : UART serial output, idle high
//   busy       : transfer in progress
//   done       : one-cycle completion pulse
//   byte_count : bytes fully sent in the current/last transfer
module at_cmd_uart_tx
  import bt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CMD_WIDTH-1:0] cmd_data,
  input  logic                 start,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [4:0]           byte_count
);

  localparam logic [4:0] LAST_IDX = 5'(CMD_BYTES - 1);
  localparam logic [4:0] FULL_CNT = 5'(CMD_BYTES);

  logic [CMD_WIDTH-1:0] shift_buf;
  logic                 byte_valid, byte_ready, byte_idle;
  logic [7:0]           byte_data;
  logic                 last_byte, byte_end, accept;

  always_comb begin
    // shift_buf[7:0] is the byte currently on the line.
    last_byte  = (shift_buf[7:0] == ASCII_CR) || (byte_count >= LAST_IDX);
    accept     = byte_idle && start;
    byte_end   = byte_ready && !byte_idle;
    byte_valid = byte_idle ? start : !last_byte;
    byte_data  = byte_idle ? cmd_data[7:0] : shift_buf[15:8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_buf  <= '0;
      byte_count <= '0;
    end else if (accept) begin
      shift_buf  <= cmd_data;
      byte_count <= '0;
    end else if (byte_end) begin
      if (byte_count != FULL_CNT) byte_count <= byte_count + 5'd1;
      if (!last_byte) shift_buf <= shift_buf >> 8;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk   (clk),
    .reset (reset),
    .valid (byte_valid),
    .data  (byte_data),
    .ready (byte_ready),
    .idle  (byte_idle),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

endmodule

// File: tb/tb_at_cmd_uart_tx.sv
module tb_at_cmd_uart_tx;

  localparam int C = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [143:0] cmd_data;
  logic         tx, busy, done;
  logic [4:0]   byte_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         done_q[$];
  int         cnt_q[$];

  at_cmd_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .cmd_data(cmd_data), .start(start),
    .tx(tx), .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endfunction

  // Reference: bytes in order from byte 0, ending after the first CR.
  function automatic int model_push(input logic [143:0] b);
    int n = 0;
    logic [7:0] v;
    for (int k = 0; k < 18; k++) begin
      v = b[8*k +: 8];
      exp_q.push_back(v);
      n++;
      if (v == 8'h0D) break;
    end
    return n;
  endfunction

  function automatic logic [143:0] mkbuf(input string s, input bit add_cr);
    logic [143:0] b = '0;
    for (int i = 0; i < s.len() && i < 18; i++) b[8*i +: 8] = s[i];
    if (add_cr && s.len() < 18) b[8*s.len() +: 8] = 8'h0D;
    return b;
  endfunction

  // UART line decoder, sampling at mid-bit on negative edges.
  bit         dec_active = 0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte;
  logic [7:0] exp_b;
  always @(negedge clk) begin
    if (reset) begin
      dec_active = 0;
    end else if (!dec_active) begin
      if (tx == 1'b0) begin
        dec_active = 1;
        dec_cnt = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt >= 5 && dec_cnt <= 33 && ((dec_cnt - 5) % C) == 0)
        dec_byte[(dec_cnt - 5) / C] = tx;
      if (dec_cnt == 37) begin
        dec_active = 0;
        chk("stop_bit", int'(tx), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", int'(dec_byte), -1);
        end else begin
          exp_b = exp_q.pop_front();
          chk("frame_byte", int'(dec_byte), int'(exp_b));
        end
      end
    end
  end

  // Completion monitor.
  int exp_cyc;
  always @(negedge clk) begin
    if (!reset && done) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_cyc = done_q.pop_front();
        chk("done_cycle", cyc, exp_cyc);
        chk("byte_count", int'(byte_count), cnt_q.pop_front());
        chk("busy_at_done", int'(busy), 0);
        chk("frames_left_at_done", exp_q.size(), 0);
      end
    end
  end

  // Caller positions at a negedge; start is accepted at the next posedge.
  task automatic send(input logic [143:0] b);
    int n, e0;
    cmd_data = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
    n = model_push(b);
    done_q.push_back(e0 + 10 * n * C);
    cnt_q.push_back(n);
    chk("tx_low_after_e0", int'(tx), 0);
    chk("busy_after_e0", int'(busy), 1);
  endtask

  // Returns positioned #1 after the negedge of the done cycle.
  task automatic wait_done(input string nm);
    int t = 0;
    bit seen = 0;
    while (!seen && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
      if (done) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  logic [143:0] rb;
  int           crp;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd_data = '0;
    #1;
    chk("reset_tx", int'(tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_count", int'(byte_count), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // TX command with payload and final CR in byte 17.
    send(mkbuf("AT+BLEUARTTX=1234", 1'b1));
    wait_done("tx_cmd");

    // Back-to-back: start in the IDLE cycle right after done.
    @(negedge clk);
    send(mkbuf("AT+BLEUARTRX", 1'b1));
    wait_done("rx_cmd");
    repeat (20) @(negedge clk);
    chk("rx_idle_tx", int'(tx), 1);
    chk("rx_idle_busy", int'(busy), 0);

    // No terminator.
    send({144{1'b1}});
    wait_done("all_ones");
    repeat (5) @(negedge clk);

    // Start during byte 3 is ignored.
    send(mkbuf("AT+BLEUARTRX", 1'b1));
    repeat (30 * C + 5) @(negedge clk);
    cmd_data = {144{1'b1}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_busy");
    repeat (60) @(negedge clk);
    chk("ignored_busy", int'(busy), 0);
    chk("ignored_frames", exp_q.size(), 0);

    // Reset during data bit 4 of byte 2.
    @(negedge clk);
    send(mkbuf("AT+BLEUARTTX=1234", 1'b1));
    repeat (25 * C) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async_tx", int'(tx), 1);
    chk("reset_async_busy", int'(busy), 0);
    chk("reset_async_done", int'(done), 0);
    exp_q.delete();
    done_q.delete();
    cnt_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send(mkbuf("AT+BLEUARTRX", 1'b1));
    wait_done("after_reset");
    repeat (3) @(negedge clk);

    // Random buffers, CR at a random position or absent.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 18; k++) rb[8*k +: 8] = 8'($urandom_range(0, 255));
      crp = $urandom_range(0, 22);
      if (crp < 18) rb[8*crp +: 8] = 8'h0D;
      send(rb);
      wait_done("random");
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    chk("final_frames_pending", exp_q.size(), 0);
    chk("final_done_pending", done_q.size(), 0);
    chk("final_tx_idle", int'(tx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
